// File: rtl/menu_nav_pkg.sv
// Shared constants for the menu navigator: FSM state encodings and the
// width of the key auto-repeat counters.
package menu_nav_pkg;
  localparam int CNT_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WELCOME = 2'd1;
  localparam logic [1:0] ST_MENU    = 2'd2;
  localparam logic [1:0] ST_ITEM    = 2'd3;
endpackage

// File: rtl/menu_key_repeat.sv
// Rising-edge detector plus held-key auto-repeat: one step on the press,
// one after REPEAT_DLY held cycles, then one every REPEAT_RATE cycles.
module menu_key_repeat
  import menu_nav_pkg::*;
#(
  parameter logic [CNT_W-1:0] REPEAT_DLY  = 16'd50000,
  parameter logic [CNT_W-1:0] REPEAT_RATE = 16'd10000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  input  logic rep_en_i,
  output logic step_o
);
  logic             key_q;
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // cnt_q holds the number of cycles since the press (or since the last repeat)
  always_comb begin
    tick  = key_q & key_i & (rep_q ? (cnt_q == REPEAT_RATE) : (cnt_q == REPEAT_DLY));
    cnt_d = cnt_q;
    rep_d = rep_q;
    if (!key_i) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (!key_q) begin
      cnt_d = CNT_W'(1);
    end else if (tick) begin
      cnt_d = CNT_W'(1);
      rep_d = 1'b1;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q <= 1'b0;
      rep_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      key_q <= key_i;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
    end
  end

  assign step_o = (key_i & ~key_q) | (tick & rep_en_i);
endmodule

// File: rtl/menu_navigator.sv
// Menu navigation engine: walks the enabled entries of an N_ITEMS menu,
// opens entries, toggles per-entry option bits and auto-repeats up/down.
module menu_navigator
  import menu_nav_pkg::*;
#(
  parameter int               N_ITEMS     = 8,
  parameter int               IDX_W       = 3,
  parameter logic [N_ITEMS-1:0] OPT_INIT  = '0,
  parameter logic [CNT_W-1:0] REPEAT_DLY  = 16'd50000,
  parameter logic [CNT_W-1:0] REPEAT_RATE = 16'd10000,
  parameter bit               WRAP        = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               enter,
  input  logic [N_ITEMS-1:0] item_enable,
  output logic [1:0]         current_state,
  output logic [IDX_W-1:0]   current_menu_item,
  output logic [N_ITEMS-1:0] options,
  output logic               opt_changed,
  output logic               item_select,
  output logic               no_items
);
  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   item_q, item_d;
  logic [N_ITEMS-1:0] opt_q, opt_d;
  logic               chg_q, chg_d, sel_q, sel_d;
  logic               left_q, right_q, enter_q;
  logic               ev_left, ev_right, ev_enter, up_step, dn_step;
  logic               rep_en;

  assign ev_left  = left  & ~left_q;
  assign ev_right = right & ~right_q;
  assign ev_enter = enter & ~enter_q;
  assign rep_en   = (state_q == ST_MENU);
  assign no_items = ~|item_enable;

  menu_key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_rep_up (
    .clk(clk), .reset(reset), .key_i(up), .rep_en_i(rep_en), .step_o(up_step));
  menu_key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_rep_dn (
    .clk(clk), .reset(reset), .key_i(down), .rep_en_i(rep_en), .step_o(dn_step));

  // Nearest enabled entry in each direction, both wrapping and saturating.
  // Loops run from the far end inward so the closest hit is the last written.
  logic [IDX_W-1:0] nxt_wrap, prv_wrap, nxt_sat, prv_sat, first_en;
  logic             nxt_wrap_ok, prv_wrap_ok, nxt_sat_ok, prv_sat_ok;
  always_comb begin
    logic [IDX_W-1:0] fi, bi;
    fi = '0; bi = '0;
    nxt_wrap = item_q; prv_wrap = item_q; nxt_sat = item_q; prv_sat = item_q;
    nxt_wrap_ok = 1'b0; prv_wrap_ok = 1'b0; nxt_sat_ok = 1'b0; prv_sat_ok = 1'b0;
    first_en = '0;
    for (int off = N_ITEMS - 1; off >= 1; off--) begin
      fi = IDX_W'((int'(item_q) + off) % N_ITEMS);
      bi = IDX_W'((int'(item_q) + N_ITEMS - off) % N_ITEMS);
      if (item_enable[fi]) begin
        nxt_wrap = fi; nxt_wrap_ok = 1'b1;
        if (int'(item_q) + off < N_ITEMS) begin nxt_sat = fi; nxt_sat_ok = 1'b1; end
      end
      if (item_enable[bi]) begin
        prv_wrap = bi; prv_wrap_ok = 1'b1;
        if (int'(item_q) >= off) begin prv_sat = bi; prv_sat_ok = 1'b1; end
      end
    end
    for (int i = N_ITEMS - 1; i >= 0; i--)
      if (item_enable[i]) first_en = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    opt_d   = opt_q;
    sel_d   = 1'b0;
    chg_d   = 1'b0;
    // Highlighted entry vanished: fall back to the menu and move upward, always wrapping
    if ((state_q == ST_MENU || state_q == ST_ITEM) && !item_enable[item_q] &&
        (!no_items || state_q == ST_ITEM)) begin
      state_d = ST_MENU;
      if (nxt_wrap_ok) item_d = nxt_wrap;
    end else if (ev_left) begin
      if (state_q == ST_MENU)      state_d = ST_WELCOME;
      else if (state_q == ST_ITEM) state_d = ST_MENU;
    end else if (ev_enter) begin
      case (state_q)
        ST_IDLE: state_d = ST_WELCOME;
        ST_MENU: if (!no_items) begin state_d = ST_ITEM; sel_d = 1'b1; end
        ST_ITEM: begin opt_d[item_q] = ~opt_q[item_q]; chg_d = 1'b1; end
        default: ;
      endcase
    end else if (up_step | dn_step) begin
      if (state_q == ST_MENU && (up_step ^ dn_step) && !no_items) begin
        if (dn_step) begin
          if (WRAP ? nxt_wrap_ok : nxt_sat_ok) item_d = WRAP ? nxt_wrap : nxt_sat;
        end else begin
          if (WRAP ? prv_wrap_ok : prv_sat_ok) item_d = WRAP ? prv_wrap : prv_sat;
        end
      end
    end else if (ev_right && state_q == ST_WELCOME) begin
      state_d = ST_MENU;
      item_d  = first_en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      item_q  <= '0;
      opt_q   <= OPT_INIT;
      chg_q   <= 1'b0;
      sel_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      opt_q   <= opt_d;
      chg_q   <= chg_d;
      sel_q   <= sel_d;
      left_q  <= left;
      right_q <= right;
      enter_q <= enter;
    end
  end

  assign current_state     = state_q;
  assign current_menu_item = item_q;
  assign options           = opt_q;
  assign opt_changed       = chg_q;
  assign item_select       = sel_q;
endmodule

// File: tb/tb_menu_navigator.sv
// Scoreboard bench: stimulus queues hand-computed expectations per clock,
// a monitor pops and compares them. dut0 wraps, dut1 saturates.
module tb_menu_navigator;
  import menu_nav_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, enter = 1'b0;
  logic [7:0] ie0 = 8'hFF, ie1 = 8'hFF;
  logic live1 = 1'b1;
  logic up1, down1, left1, right1, enter1;

  logic [1:0] st0, st1;
  logic [2:0] it0, it1;
  logic [7:0] op0, op1;
  logic chg0, chg1, sel0, sel1, noi0, noi1;

  assign up1 = up & live1;       assign down1  = down & live1;
  assign left1 = left & live1;   assign right1 = right & live1;
  assign enter1 = enter & live1;

  menu_navigator #(.N_ITEMS(8), .IDX_W(3), .OPT_INIT(8'h00), .REPEAT_DLY(16'd20),
                   .REPEAT_RATE(16'd5), .WRAP(1'b1)) dut0 (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .enter(enter), .item_enable(ie0), .current_state(st0), .current_menu_item(it0),
    .options(op0), .opt_changed(chg0), .item_select(sel0), .no_items(noi0));

  menu_navigator #(.N_ITEMS(8), .IDX_W(3), .OPT_INIT(8'h00), .REPEAT_DLY(16'd20),
                   .REPEAT_RATE(16'd5), .WRAP(1'b0)) dut1 (
    .clk(clk), .reset(reset), .up(up1), .down(down1), .left(left1), .right(right1),
    .enter(enter1), .item_enable(ie1), .current_state(st1), .current_menu_item(it1),
    .options(op1), .opt_changed(chg1), .item_select(sel1), .no_items(noi1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      nm;
    logic [1:0] st;
    logic [2:0] it;
    logic [7:0] op;
    logic       sel, chg, noi;
    logic [1:0] st1;
    logic [2:0] it1;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  logic e_noi = 1'b0;
  logic [2:0] e_it1 = 3'd0;
  logic [1:0] e_st1 = 2'd0;

  localparam logic [4:0] K_UP = 5'b10000, K_DN = 5'b01000, K_LT = 5'b00100,
                         K_RT = 5'b00010, K_EN = 5'b00001;

  task automatic check(input exp_t e);
    checks++;
    if (st0 !== e.st || it0 !== e.it || op0 !== e.op || sel0 !== e.sel ||
        chg0 !== e.chg || noi0 !== e.noi || st1 !== e.st1 || it1 !== e.it1 ||
        {op1, sel1, chg1, noi1} !== 11'd0) begin
      errors++;
      $display("FAIL %s: got st=%0d it=%0d op=%h sel=%b chg=%b noi=%b st1=%0d it1=%0d x1=%h, want st=%0d it=%0d op=%h sel=%b chg=%b noi=%b st1=%0d it1=%0d x1=0",
               e.nm, st0, it0, op0, sel0, chg0, noi0, st1, it1, {op1, sel1, chg1, noi1},
               e.st, e.it, e.op, e.sel, e.chg, e.noi, e.st1, e.it1);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [1:0] st, input logic [2:0] it,
                              input logic [7:0] op, input logic sel, input logic chg);
    exp_t e;
    e.due = cyc + 1; e.nm = nm; e.st = st; e.it = it; e.op = op;
    e.sel = sel; e.chg = chg; e.noi = e_noi;
    e.st1 = live1 ? st : e_st1;
    e.it1 = e_it1;
    return e;
  endfunction

  task automatic ex(input string nm, input logic [1:0] st, input logic [2:0] it,
                    input logic [7:0] op, input logic sel, input logic chg);
    sb.push_back(mk(nm, st, it, op, sel, chg));
  endtask

  task automatic drive(input logic [4:0] k);
    @(negedge clk);
    {up, down, left, right, enter} = k;
  endtask

  task automatic pulse(input string nm, input logic [4:0] k, input logic [1:0] st,
                       input logic [2:0] it, input logic [7:0] op, input logic sel,
                       input logic chg);
    drive(k);
    ex(nm, st, it, op, sel, chg);
    drive(5'b0);
    ex({nm, "_after"}, st, it, op, 1'b0, 1'b0);
  endtask

  // Monitor: compare every expectation that falls due at this clock
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].due <= cyc) check(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, want end before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t d;
    repeat (2) @(negedge clk);
    ex("reset", ST_IDLE, 0, 8'h00, 0, 0);
    drive(5'b0); reset = 1'b1;
    ex("idle", ST_IDLE, 0, 8'h00, 0, 0);

    pulse("enter_welcome", K_EN, ST_WELCOME, 0, 8'h00, 0, 0);
    pulse("right_menu",    K_RT, ST_MENU,    0, 8'h00, 0, 0);

    // skip a disabled entry, then wrap (dut0) versus saturate (dut1)
    drive(5'b0); ie0 = 8'b1111_1011; ie1 = 8'b1111_1011;
    ex("ie_fb", ST_MENU, 0, 8'h00, 0, 0);
    e_it1 = 3'd1; pulse("dn_1",     K_DN, ST_MENU, 1, 8'h00, 0, 0);
    e_it1 = 3'd3; pulse("dn_skip2", K_DN, ST_MENU, 3, 8'h00, 0, 0);
    e_it1 = 3'd4; pulse("dn_4",     K_DN, ST_MENU, 4, 8'h00, 0, 0);
    e_it1 = 3'd5; pulse("dn_5",     K_DN, ST_MENU, 5, 8'h00, 0, 0);
    e_it1 = 3'd6; pulse("dn_6",     K_DN, ST_MENU, 6, 8'h00, 0, 0);
    e_it1 = 3'd7; pulse("dn_7",     K_DN, ST_MENU, 7, 8'h00, 0, 0);
    pulse("dn_wrap", K_DN, ST_MENU, 0, 8'h00, 0, 0);
    live1 = 1'b0; e_st1 = ST_MENU;

    pulse("up_wrap",  K_UP, ST_MENU, 7, 8'h00, 0, 0);
    pulse("up_6",     K_UP, ST_MENU, 6, 8'h00, 0, 0);
    pulse("up_5",     K_UP, ST_MENU, 5, 8'h00, 0, 0);
    pulse("up_4",     K_UP, ST_MENU, 4, 8'h00, 0, 0);
    pulse("up_3",     K_UP, ST_MENU, 3, 8'h00, 0, 0);
    pulse("up_skip2", K_UP, ST_MENU, 1, 8'h00, 0, 0);

    drive(5'b0); ie0 = 8'hFF;
    ex("ie_ff", ST_MENU, 1, 8'h00, 0, 0);
    pulse("dn_2",        K_DN, ST_MENU, 2, 8'h00, 0, 0);
    pulse("open2",       K_EN, ST_ITEM, 2, 8'h00, 1, 0);
    pulse("item_dn_ign", K_DN, ST_ITEM, 2, 8'h00, 0, 0);
    pulse("opt_on",      K_EN, ST_ITEM, 2, 8'h04, 0, 1);
    pulse("opt_off",     K_EN, ST_ITEM, 2, 8'h00, 0, 1);
    pulse("left_menu",   K_LT, ST_MENU, 2, 8'h00, 0, 0);

    pulse("updn_same",   K_UP | K_DN, ST_MENU, 2, 8'h00, 0, 0);
    pulse("open2b",      K_EN,        ST_ITEM, 2, 8'h00, 1, 0);
    pulse("enter_left",  K_EN | K_LT, ST_MENU, 2, 8'h00, 0, 0);

    // auto-repeat: press at cycle 1, then 20 cycles delay, then every 5
    pulse("up_1", K_UP, ST_MENU, 1, 8'h00, 0, 0);
    pulse("up_0", K_UP, ST_MENU, 0, 8'h00, 0, 0);
    for (int c = 1; c <= 31; c++) begin
      drive(K_DN);
      ex($sformatf("rep_c%0d", c), ST_MENU,
         (c < 21) ? 3'd1 : (c < 26) ? 3'd2 : (c < 31) ? 3'd3 : 3'd4, 8'h00, 0, 0);
    end
    for (int c = 1; c <= 8; c++) begin
      drive(5'b0);
      ex($sformatf("rep_rel%0d", c), ST_MENU, 4, 8'h00, 0, 0);
    end

    // highlighted entry disabled while open, then no entries at all
    pulse("up_3b", K_UP, ST_MENU, 3, 8'h00, 0, 0);
    pulse("open3", K_EN, ST_ITEM, 3, 8'h00, 1, 0);
    pulse("opt3",  K_EN, ST_ITEM, 3, 8'h08, 0, 1);
    drive(5'b0); ie0 = 8'hF7;
    ex("dis3", ST_MENU, 4, 8'h08, 0, 0);
    drive(5'b0); ie0 = 8'h00; e_noi = 1'b1;
    ex("none", ST_MENU, 4, 8'h08, 0, 0);
    pulse("none_enter", K_EN, ST_MENU, 4, 8'h08, 0, 0);
    pulse("none_dn",    K_DN, ST_MENU, 4, 8'h08, 0, 0);
    drive(5'b0); ie0 = 8'hFF; e_noi = 1'b0;
    ex("ie_back", ST_MENU, 4, 8'h08, 0, 0);

    // reset in the middle of a held key
    drive(K_DN); ex("hold1", ST_MENU, 5, 8'h08, 0, 0);
    drive(K_DN); ex("hold2", ST_MENU, 5, 8'h08, 0, 0);
    @(negedge clk);
    #3 reset = 1'b0; e_st1 = ST_IDLE; e_it1 = 3'd0;
    #1;
    d = mk("rst_async", ST_IDLE, 0, 8'h00, 0, 0);
    check(d);
    ex("rst_hold", ST_IDLE, 0, 8'h00, 0, 0);
    drive(5'b0); ex("rst_hold2", ST_IDLE, 0, 8'h00, 0, 0);
    drive(5'b0); reset = 1'b1;
    ex("post_rst", ST_IDLE, 0, 8'h00, 0, 0);
    pulse("post_enter", K_EN, ST_WELCOME, 0, 8'h00, 0, 0);

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/menu_navigator.md
Name: menu_navigator

Overview:
Parametrised menu-navigation engine for the phone user interface. It replaces the fixed menu logic inside user_interface. It takes the debounced front-panel buttons and walks a configurable list of N_ITEMS menu entries. Entries can be hidden at run time (for example, the voicemail entry is hidden until a CF card is detected). It also keeps one on/off option bit per entry, and it generates held-key auto-repeat that the current design does not have.

Parameters:
N_ITEMS, 8, number of menu entries (2..64)
IDX_W, 3, width of the item index; must satisfy 2**IDX_W >= N_ITEMS
OPT_INIT, 8'h00, reset value of the option bits (width N_ITEMS)
REPEAT_DLY, 16'd50000, number of cycles up/down must be held before the first auto-repeat step
REPEAT_RATE, 16'd10000, number of cycles between later auto-repeat steps
WRAP, 1, 1 = navigation wraps at the ends of the list; 0 = navigation saturates

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
up  in  1  debounced level, synchronous to clk
down  in  1  debounced level, synchronous to clk
left  in  1  debounced level, synchronous to clk
right  in  1  debounced level, synchronous to clk
enter  in  1  debounced level, synchronous to clk
item_enable  in  N_ITEMS  1 = entry is visible and selectable
current_state  out  2  navigator state (encoding in package)
current_menu_item  out  IDX_W  index of the highlighted entry
options  out  N_ITEMS  option bit per entry
opt_changed  out  1  one-cycle pulse when any option bit toggles
item_select  out  1  one-cycle pulse when an entry is opened
no_items  out  1  high when item_enable is all zero

Behaviour:
- Reset (reset low, asynchronous):
  - current_state = ST_IDLE, current_menu_item = 0, options = OPT_INIT.
  - opt_changed = 0, item_select = 0.
  - All key history and repeat counters cleared.
- Key events:
  - A key event is a rising edge: the level is 1 now and was 0 last cycle.
  - A key event sampled at edge k updates the registered outputs at that same edge k. This gives 1-cycle latency from assertion.
- Event priority within one cycle: left > enter > up/down > right.
  - Only the highest-priority event acts.
  - If up and down events occur in the same cycle, both are ignored.
- Auto-repeat (up/down only):
  - While the key stays high, a synthetic step is issued REPEAT_DLY cycles after its edge.
  - After that, a step is issued every REPEAT_RATE cycles.
  - The counter clears when the key drops.
  - Auto-repeat is active only in ST_MENU.
- States and transitions:
  - ST_IDLE: enter -> ST_WELCOME.
  - ST_WELCOME: right -> ST_MENU. When entering ST_MENU, current_menu_item is the lowest enabled index; it is 0 if none are enabled.
  - ST_MENU, down: move to the next enabled index above the current one.
  - ST_MENU, up: move to the next enabled index below the current one.
    - Disabled entries are skipped in a single step (combinational search).
    - If WRAP=1, the search wraps past N_ITEMS-1 and 0.
    - If WRAP=0 and no enabled entry lies in that direction, the index holds.
  - ST_MENU, enter: if no_items=0, go to ST_ITEM and pulse item_select. If no_items=1, enter is ignored.
  - ST_MENU, left: go to ST_WELCOME.
  - ST_ITEM, enter: options[current_menu_item] toggles and opt_changed pulses.
  - ST_ITEM, left: go to ST_MENU.
  - ST_ITEM, up/down: ignored.
- The highlighted entry becomes disabled:
  - In ST_MENU: the next cycle moves to the next enabled index upward, with wrap regardless of WRAP.
  - In ST_ITEM: the next cycle forces the state to ST_MENU and applies the same move.
- All entries disabled:
  - no_items = 1.
  - current_menu_item holds its value.
  - up and down are ignored.
- Option bits persist across state changes. Only reset restores OPT_INIT.
- Indices at or above N_ITEMS are never produced.

Decomposition:
- Package menu_nav_pkg holds:
  - state encodings: ST_IDLE=0, ST_WELCOME=1, ST_MENU=2, ST_ITEM=3
  - the 16-bit repeat-counter width constant
- Sub-module menu_key_repeat (one instance each for up and down):
  - does edge detection plus the REPEAT_DLY/REPEAT_RATE counter
  - outputs a one-cycle step pulse
- left, right and enter use plain edge detection inside menu_navigator.

Test Plan:
1. Reset low, then release. Pulse enter, then pulse right.
   -> current_state goes 0 -> 1 -> 2; current_menu_item = 0; options = 8'h00.
2. item_enable = 8'b1111_1011. From item 1, pulse down.
   -> item becomes 3 (item 2 skipped).
   Then from item 7, pulse down with WRAP=1.
   -> item becomes 0.
   Repeat the item-7 step with WRAP=0.
   -> item stays 7.
3. In ST_MENU at item 2 with item 2 enabled, pulse enter.
   -> item_select pulses for 1 cycle; state = 3.
   Pulse enter.
   -> options = 8'h04; opt_changed pulses.
   Pulse enter again.
   -> options = 8'h00.
   Pulse left.
   -> state = 2.
4. Use REPEAT_DLY=20 and REPEAT_RATE=5 with all items enabled. Hold down for 31 cycles from item 0.
   -> item steps to 1 at cycle 1, 2 at cycle 21, 3 at cycle 26, 4 at cycle 31. No further steps after release.
5. Pulse up and down in the same cycle.
   -> no change.
   Pulse enter and left in the same cycle while in ST_ITEM.
   -> state = 2 and options unchanged.
6. In ST_ITEM at item 3, clear item_enable[3].
   -> next cycle: state = 2, item = 4.
   Set item_enable = 0.
   -> no_items = 1, and enter is ignored.
   Assert reset mid-hold.
   -> all outputs return to reset values immediately.
